alu_share_arb: RTL and testbench

- Shares the single 64-bit ALU among NREQ requesters, e.g. execute, branch compare and address generation.
- Round-robin arbitration with valid/ready handshakes on the request and response sides.
- Registers the ALU result with its zero flag and requester ID into a one-entry output buffer.
- Sits between the decode/issue stage and the shared ALU instance.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_share_arb.sv | 197 +++++++++++++++++++
 tb/tb_alu_share_arb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode type, legal opcode constants and the legality check.
package alu_pkg;

    localparam int unsigned OPW = 4;

    typedef logic [OPW-1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;

    function automatic logic alu_op_legal(input alu_op_t op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Existing arithmetic ALU: subtract on ALU_SUB, add otherwise.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [OPW-1:0]  ALUop,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] out
);

    always_comb begin
        out = in1 + in2;
        if (alu_op_t'(ALUop) == ALU_SUB) begin
            out = in1 - in2;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past last_i and wraps modulo N.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_c_o,
    output logic [IDW-1:0] idx_c_o
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDW'((32'(last_i) + k) % N);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                idx_c_o = cand;
            end
        end
        if (en_i && found) begin
            gnt_c_o[idx_c_o] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters with a one-entry response buffer.
// Optional perf counters enabled by defining ALU_SHARE_ARB_PERF_EN.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter  int unsigned XLEN = 64,
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_err
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [NREQ*32-1:0]   perf_grant_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int unsigned CNTW = 32;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_err_q, rsp_err_d;
    logic [IDW-1:0]  last_q, last_d;

    logic            can_issue_c;
    logic            arb_en_c;
    logic            fire_c;
    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  gnt_idx_c;
    alu_op_t         sel_op_c;
    logic [XLEN-1:0] sel_a_c, sel_b_c;
    logic [XLEN-1:0] alu_out_c;
    logic [XLEN-1:0] buf_res_c;
    logic            buf_err_c;

    assign can_issue_c = !rsp_valid_q || rsp_ready;
    assign arb_en_c    = can_issue_c && rst_n;
    assign fire_c      = |gnt_c;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .en_i    (arb_en_c),
        .gnt_c_o (gnt_c),
        .idx_c_o (gnt_idx_c)
    );

    assign req_ready = gnt_c;

    // Route the winning requester's opcode and operands to the ALU.
    always_comb begin
        sel_op_c = '0;
        sel_a_c  = '0;
        sel_b_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx_c == IDW'(i)) begin
                sel_op_c = alu_op_t'(req_op[OPW*i +: OPW]);
                sel_a_c  = req_a[XLEN*i +: XLEN];
                sel_b_c  = req_b[XLEN*i +: XLEN];
            end
        end
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .ALUop (sel_op_c),
        .in1   (sel_a_c),
        .in2   (sel_b_c),
        .out   (alu_out_c)
    );

    // Logic ops and the illegal-op override sit in front of the buffer.
    always_comb begin
        buf_err_c = !alu_op_legal(sel_op_c);
        buf_res_c = '0;
        case (sel_op_c)
            ALU_AND:          buf_res_c = sel_a_c & sel_b_c;
            ALU_OR:           buf_res_c = sel_a_c | sel_b_c;
            ALU_ADD, ALU_SUB: buf_res_c = alu_out_c;
            default:          buf_res_c = '0;
        endcase
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        last_d       = last_q;
        if (fire_c) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_idx_c;
            rsp_result_d = buf_res_c;
            rsp_zero_d   = (buf_res_c == '0);
            rsp_err_d    = buf_err_c;
            last_d       = gnt_idx_c;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            last_q       <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            last_q       <= last_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [CNTW-1:0] grant_cnt_q [NREQ];
    logic [CNTW-1:0] grant_cnt_d [NREQ];
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
        end
        if (perf_clr) begin
            stall_cnt_d = '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_d[i] = '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_c[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_d[i] = grant_cnt_q[i] + CNTW'(1);
                end
            end
            if ((|req_valid) && !can_issue_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            perf_grant_cnt[CNTW*i +: CNTW] = grant_cnt_q[i];
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: expected responses queued at grant time, checked on drain.
module tb_alu_share_arb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*4-1:0]    req_op;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_zero;
    logic                 rsp_err;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic                 perf_clr = 1'b0;
    logic [NREQ*32-1:0]   perf_grant_cnt;
    logic [31:0]          perf_stall_cnt;
`endif

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] res;
        logic            z;
        logic            e;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            mon_e;
    int              checks   = 0;
    int              failures = 0;
    logic [3:0]      op_v [NREQ];
    logic [XLEN-1:0] a_v  [NREQ];
    logic [XLEN-1:0] b_v  [NREQ];

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    always #5 clk = ~clk;

    alu_share_arb #(
        .XLEN (XLEN),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[4*i +: 4]       = op_v[i];
            req_a[XLEN*i +: XLEN]  = a_v[i];
            req_b[XLEN*i +: XLEN]  = b_v[i];
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One cycle: drive request/ready, check the grant, queue the hand-computed response.
    task automatic step(input string name, input logic [3:0] vld, input logic rdy,
                        input logic [3:0] exp_rdy, input logic [XLEN-1:0] er,
                        input logic ez, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        req_valid = vld;
        rsp_ready = rdy;
        @(negedge clk);
        chk({name, "_req_ready"}, XLEN'(req_ready), XLEN'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            e.id = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) e.id = IDW'(i);
            end
            e.res = er;
            e.z   = ez;
            e.e   = ee;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every consumed response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d result=%h, required no response", rsp_id, rsp_result);
            end else begin
                mon_e = sb_q.pop_front();
                if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== mon_e) begin
                    failures++;
                    $display("FAIL rsp_data: got id=%0d res=%h z=%b e=%b, required id=%0d res=%h z=%b e=%b",
                             rsp_id, rsp_result, rsp_zero, rsp_err, mon_e.id, mon_e.res, mon_e.z, mon_e.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            op_v[i] = 4'b0010;
            a_v[i]  = XLEN'(i);
            b_v[i]  = XLEN'(10);
        end

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", XLEN'(req_ready), '0);
        chk("reset_rsp_valid", XLEN'(rsp_valid), '0);
        chk("reset_rsp_id", XLEN'(rsp_id), '0);
        chk("reset_rsp_result", rsp_result, '0);
        chk("reset_rsp_zero_err", XLEN'({rsp_zero, rsp_err}), '0);
`ifdef ALU_SHARE_ARB_PERF_EN
        chk("reset_perf_stall", XLEN'(perf_stall_cnt), '0);
`endif
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        // All four requesting ADD a=i, b=10: grants 0,1,2,3,0
        step("rr0", 4'b1111, 1'b1, 4'b0001, XLEN'(10), 1'b0, 1'b0);
        step("rr1", 4'b1111, 1'b1, 4'b0010, XLEN'(11), 1'b0, 1'b0);
        step("rr2", 4'b1111, 1'b1, 4'b0100, XLEN'(12), 1'b0, 1'b0);
        step("rr3", 4'b1111, 1'b1, 4'b1000, XLEN'(13), 1'b0, 1'b0);
        step("rr4", 4'b1111, 1'b1, 4'b0001, XLEN'(10), 1'b0, 1'b0);
        step("rr_drain", 4'b0000, 1'b1, 4'b0000, '0, 1'b0, 1'b0);

        // Req 2 alone, SUB 5-5
        op_v[2] = 4'b0110; a_v[2] = XLEN'(5); b_v[2] = XLEN'(5);
        step("sub", 4'b0100, 1'b1, 4'b0100, '0, 1'b1, 1'b0);
        step("sub_drain", 4'b0000, 1'b1, 4'b0000, '0, 1'b0, 1'b0);
        chk("sub_rsp_valid", XLEN'(rsp_valid), XLEN'(1));
        chk("sub_rsp_id", XLEN'(rsp_id), XLEN'(2));

        // Backpressure: req 3 loads, req 1 waits three stalled cycles
        step("bp_load", 4'b1000, 1'b0, 4'b1000, XLEN'(13), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("bp_stall", 4'b0010, 1'b0, 4'b0000, '0, 1'b0, 1'b0);
            chk("bp_hold_valid", XLEN'(rsp_valid), XLEN'(1));
            chk("bp_hold_id", XLEN'(rsp_id), XLEN'(3));
            chk("bp_hold_result", rsp_result, XLEN'(13));
        end
        step("bp_release", 4'b0010, 1'b1, 4'b0010, XLEN'(11), 1'b0, 1'b0);
        step("bp_drain", 4'b0000, 1'b1, 4'b0000, '0, 1'b0, 1'b0);

        // Illegal op on req 0
        op_v[0] = 4'b1111; a_v[0] = XLEN'(7); b_v[0] = XLEN'(9);
        step("illegal", 4'b0001, 1'b1, 4'b0001, '0, 1'b1, 1'b1);

        // Wraparound and logic ops
        op_v[1] = 4'b0110; a_v[1] = '0; b_v[1] = XLEN'(1);
        step("sub_wrap", 4'b0010, 1'b1, 4'b0010, ONES, 1'b0, 1'b0);
        op_v[2] = 4'b0010; a_v[2] = ONES; b_v[2] = XLEN'(1);
        step("add_wrap", 4'b0100, 1'b1, 4'b0100, '0, 1'b1, 1'b0);
        op_v[3] = 4'b0000; a_v[3] = XLEN'(16'hF0F0); b_v[3] = XLEN'(16'hFF00);
        step("and", 4'b1000, 1'b1, 4'b1000, XLEN'(16'hF000), 1'b0, 1'b0);
        op_v[0] = 4'b0001; a_v[0] = XLEN'(8'h0F); b_v[0] = XLEN'(8'hF0);
        step("or", 4'b0001, 1'b1, 4'b0001, XLEN'(8'hFF), 1'b0, 1'b0);

        // Two contenders alternate
        step("fair_a", 4'b1010, 1'b1, 4'b0010, ONES, 1'b0, 1'b0);
        step("fair_b", 4'b1010, 1'b1, 4'b1000, XLEN'(16'hF000), 1'b0, 1'b0);
        step("fair_drain", 4'b0000, 1'b1, 4'b0000, '0, 1'b0, 1'b0);

        // Reset while stalled discards the response and restores priority to req 0
        a_v[2] = XLEN'(2); b_v[2] = XLEN'(10);
        step("rst_load", 4'b0100, 1'b0, 4'b0100, XLEN'(12), 1'b0, 1'b0);
        step("rst_stall", 4'b0100, 1'b0, 4'b0000, '0, 1'b0, 1'b0);
        chk("rst_stall_valid", XLEN'(rsp_valid), XLEN'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", XLEN'(req_ready), '0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rst_mid_rsp_valid", XLEN'(rsp_valid), '0);
`ifdef ALU_SHARE_ARB_PERF_EN
        chk("rst_mid_perf_grant", XLEN'(perf_grant_cnt[63:0]), '0);
        chk("rst_mid_perf_stall", XLEN'(perf_stall_cnt), '0);
`endif
        step("post_rst", 4'b1001, 1'b1, 4'b0001, XLEN'(8'hFF), 1'b0, 1'b0);
        step("post_rst_drain", 4'b0000, 1'b1, 4'b0000, '0, 1'b0, 1'b0);

        @(posedge clk); @(negedge clk);
        chk("sb_empty", XLEN'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
